// File: rtl/uart_cmd_decoder_pkg.sv
// i2c_pkg: shared constants, mode encodings and FSM state type for the UART command decoder
package i2c_pkg;

    localparam logic [2:0] SYNC = 3'b101;

    typedef enum logic [2:0] {
        MODE_SET_PTR = 3'b000,
        MODE_RD2     = 3'b001,
        MODE_RD1     = 3'b010,
        MODE_WR1     = 3'b011,
        MODE_WR2     = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA_HI,
        ST_DATA_LO
    } state_e;

    function automatic logic mode_valid(input logic [2:0] m);
        return m <= MODE_WR2;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: byte stream in, instruction-queue write port out
interface uart_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        buffers_full;
    logic        wr_opbuffer;
    logic        wr_addrbuffer;
    logic        wr_databuffer1;
    logic        wr_databuffer2;
    logic        initiate;
    logic [2:0]  mode;
    logic [7:0]  addr_pointer;
    logic [15:0] wr_data;
    logic        frame_error;
    logic        cmd_dropped;

    modport master (
        output rx_data, rx_valid, buffers_full,
        input  wr_opbuffer, wr_addrbuffer, wr_databuffer1, wr_databuffer2, initiate,
        input  mode, addr_pointer, wr_data, frame_error, cmd_dropped
    );

    modport slave (
        input  rx_data, rx_valid, buffers_full,
        output wr_opbuffer, wr_addrbuffer, wr_databuffer1, wr_databuffer2, initiate,
        output mode, addr_pointer, wr_data, frame_error, cmd_dropped
    );
endinterface

// File: rtl/uart_cmd_decoder_frame_timer.sv
// frame_timer: loadable inter-byte counter with clear/enable and an expiry flag at TIMEOUT_CYCLES-1
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    assign o_expired = i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));

    // Clear has priority over load, load over counting
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles header/address/data UART bytes into one instruction-queue write
module uart_cmd_decoder
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    uart_cmd_decoder_if.slave bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e      r_state;
    logic        r_strobe;
    logic        r_frame_error;
    logic        r_cmd_dropped;
    logic [2:0]  r_mode;
    logic [7:0]  r_addr;
    logic [15:0] r_wr_data;
    logic        w_expired;
    logic        w_hdr_sync;

    assign w_hdr_sync = bus.rx_data[7:5] == SYNC;

    // Timer runs only while a frame is open and restarts on every byte
    frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (r_state == ST_IDLE || bus.rx_valid || w_expired),
        .i_en       (r_state != ST_IDLE),
        .i_load     (1'b0),
        .i_load_val ({TW{1'b0}}),
        .o_expired  (w_expired)
    );

    // Frame FSM; a received byte always beats a coincident timeout
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_strobe      <= 1'b0;
            r_frame_error <= 1'b0;
            r_cmd_dropped <= 1'b0;
            r_mode        <= '0;
            r_addr        <= '0;
            r_wr_data     <= '0;
        end else begin
            r_strobe      <= 1'b0;
            r_frame_error <= 1'b0;
            r_cmd_dropped <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    ST_IDLE:
                        if (w_hdr_sync) begin
                            if (!mode_valid(bus.rx_data[2:0]))
                                r_frame_error <= 1'b1;
                            else begin
                                r_mode    <= bus.rx_data[2:0];
                                r_wr_data <= '0;
                                r_state   <= ST_ADDR;
                            end
                        end
                    ST_ADDR: begin
                        r_addr <= bus.rx_data;
                        if (r_mode == MODE_WR1)
                            r_state <= ST_DATA_LO;
                        else if (r_mode == MODE_WR2)
                            r_state <= ST_DATA_HI;
                        else begin
                            r_state       <= ST_IDLE;
                            r_strobe      <= !bus.buffers_full;
                            r_cmd_dropped <= bus.buffers_full;
                        end
                    end
                    ST_DATA_HI: begin
                        r_wr_data[15:8] <= bus.rx_data;
                        r_state         <= ST_DATA_LO;
                    end
                    ST_DATA_LO: begin
                        r_wr_data[7:0] <= bus.rx_data;
                        r_state        <= ST_IDLE;
                        r_strobe       <= !bus.buffers_full;
                        r_cmd_dropped  <= bus.buffers_full;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_expired) begin
                r_state       <= ST_IDLE;
                r_frame_error <= 1'b1;
            end
        end

    assign bus.wr_opbuffer    = r_strobe;
    assign bus.wr_addrbuffer  = r_strobe;
    assign bus.wr_databuffer1 = r_strobe;
    assign bus.wr_databuffer2 = r_strobe;
    assign bus.initiate       = r_strobe;
    assign bus.mode           = r_mode;
    assign bus.addr_pointer   = r_addr;
    assign bus.wr_data        = r_wr_data;
    assign bus.frame_error    = r_frame_error;
    assign bus.cmd_dropped    = r_cmd_dropped;

endmodule
